// File: rtl/eth_pkg.sv
// Shared constants and FSM state type for the Ethernet ARP extraction stage.
package eth_pkg;
  localparam logic [15:0] ETHERTYPE_ARP     = 16'h0806;
  localparam logic [15:0] ETHERTYPE_VLAN    = 16'h8100;
  localparam logic [47:0] MAC_BCAST         = 48'hFFFF_FFFF_FFFF;
  localparam int          ARP_PAYLOAD_WORDS = 7;
  localparam logic [2:0]  ARP_LAST_IDX      = 3'd6;

  typedef enum logic [2:0] {
    HDR     = 3'd0,
    VLAN    = 3'd1,
    PAYLOAD = 3'd2,
    DRAIN   = 3'd3,
    DISCARD = 3'd4,
    SEND    = 3'd5
  } state_t;
endpackage

// File: rtl/arp_payload_buf.sv
// 7x32 ARP payload store: realigns the 2-byte-offset payload through a 16-bit hold register
// and replays it word by word through a read index.
module arp_payload_buf
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic [15:0] i_hold_init,
  input  logic        i_wr_en,
  input  logic [31:0] i_wr_data,
  input  logic        i_rd_adv,
  output logic [2:0]  o_wr_idx,
  output logic [2:0]  o_rd_idx,
  output logic [31:0] o_rd_data
);
  logic [31:0] mem_q [ARP_PAYLOAD_WORDS];
  logic [31:0] mem_d [ARP_PAYLOAD_WORDS];
  logic [15:0] hold_q, hold_d;
  logic [2:0]  wr_q, wr_d, rd_q, rd_d;

  assign o_wr_idx  = wr_q;
  assign o_rd_idx  = rd_q;
  assign o_rd_data = mem_q[rd_q];

  always_comb begin
    mem_d  = mem_q;
    hold_d = hold_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    if (i_start) begin
      hold_d = i_hold_init;
      wr_d   = 3'd0;
      rd_d   = 3'd0;
    end else if (i_wr_en) begin
      // Upper half of each stored word comes from the previous beat's low half.
      mem_d[wr_q] = {hold_q, i_wr_data[31:16]};
      hold_d      = i_wr_data[15:0];
      if (wr_q != ARP_LAST_IDX) begin
        wr_d = wr_q + 3'd1;
      end
    end else if (i_rd_adv && (rd_q != ARP_LAST_IDX)) begin
      rd_d = rd_q + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ARP_PAYLOAD_WORDS; i++) begin
        mem_q[i] <= 32'd0;
      end
      hold_q <= 16'd0;
      wr_q   <= 3'd0;
      rd_q   <= 3'd0;
    end else begin
      mem_q  <= mem_d;
      hold_q <= hold_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
    end
  end
endmodule

// File: rtl/eth_arp_extractor.sv
// Ethernet RX filter feeding the ARP responder: accepts local/broadcast ARP frames, emits the 7-word payload
// after the whole frame is in. Define ARP_EXTRACT_VLAN_EN to also accept single 802.1Q-tagged ARP frames.
module eth_arp_extractor
  import eth_pkg::*;
#(
  parameter bit ACCEPT_BCAST  = 1'b1,
  parameter bit CHECK_DST_MAC = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_rx_data,
  input  logic        i_rx_valid,
  input  logic        i_rx_last,
  output logic        o_rx_ready,
  output logic [31:0] o_arp_data,
  output logic        o_arp_valid,
  output logic        o_arp_last,
  input  logic        i_arp_ready,
  input  logic [47:0] i_local_mac,
  input  logic        i_enable,
  output logic        o_frm_accept,
  output logic        o_frm_drop
);
  state_t      state_q, state_d;
  logic [3:0]  widx_q, widx_d;
  logic        hi_local_q, hi_local_d, hi_bcast_q, hi_bcast_d;
  logic        mac_ok_q, mac_ok_d, en_q, en_d, accept_q, accept_d;
  logic        beat, type_arp, lo_local, lo_bcast;
  logic        buf_start, buf_wr, buf_rd_adv;
  logic [2:0]  wr_idx, rd_idx;
  logic [31:0] rd_data;

  assign o_rx_ready   = (state_q != SEND) && !rst;
  assign beat         = i_rx_valid && o_rx_ready;
  assign type_arp     = (i_rx_data[31:16] == ETHERTYPE_ARP);
  assign lo_local     = (i_rx_data[31:16] == i_local_mac[15:0]);
  assign lo_bcast     = (i_rx_data[31:16] == MAC_BCAST[15:0]);
  assign o_arp_valid  = (state_q == SEND);
  assign o_arp_data   = o_arp_valid ? rd_data : 32'd0;
  assign o_arp_last   = o_arp_valid && (rd_idx == ARP_LAST_IDX);
  assign o_frm_accept = accept_q;

  arp_payload_buf u_buf (
    .clk         (clk),
    .rst         (rst),
    .i_start     (buf_start),
    .i_hold_init (i_rx_data[15:0]),
    .i_wr_en     (buf_wr),
    .i_wr_data   (i_rx_data),
    .i_rd_adv    (buf_rd_adv),
    .o_wr_idx    (wr_idx),
    .o_rd_idx    (rd_idx),
    .o_rd_data   (rd_data)
  );

  always_comb begin
    state_d    = state_q;
    widx_d     = widx_q;
    hi_local_d = hi_local_q;
    hi_bcast_d = hi_bcast_q;
    mac_ok_d   = mac_ok_q;
    en_d       = en_q;
    accept_d   = 1'b0;
    o_frm_drop = 1'b0;
    buf_start  = 1'b0;
    buf_wr     = 1'b0;
    buf_rd_adv = 1'b0;

    if (beat) begin
      if (i_rx_last) begin
        widx_d = 4'd0;
      end else if (widx_q != 4'd15) begin
        widx_d = widx_q + 4'd1;
      end
    end

    case (state_q)
      HDR: begin
        if (beat) begin
          // Destination MAC straddles w0/w1; compare halves and combine at w1.
          if (widx_q == 4'd0) begin
            hi_local_d = (i_rx_data == i_local_mac[47:16]);
            hi_bcast_d = (i_rx_data == MAC_BCAST[47:16]);
            en_d       = i_enable;
          end
          if (widx_q == 4'd1) begin
            mac_ok_d = !CHECK_DST_MAC || (hi_local_q && lo_local) ||
                       (ACCEPT_BCAST && hi_bcast_q && lo_bcast);
          end
          if (i_rx_last) begin
            o_frm_drop = 1'b1;
          end else if (widx_q == 4'd3) begin
            if (mac_ok_q && en_q && type_arp) begin
              buf_start = 1'b1;
              state_d   = PAYLOAD;
`ifdef ARP_EXTRACT_VLAN_EN
            end else if (mac_ok_q && en_q && (i_rx_data[31:16] == ETHERTYPE_VLAN)) begin
              state_d = VLAN;
`endif
            end else begin
              state_d = DISCARD;
            end
          end
        end
      end
`ifdef ARP_EXTRACT_VLAN_EN
      VLAN: begin
        if (beat) begin
          if (i_rx_last) begin
            o_frm_drop = 1'b1;
            state_d    = HDR;
          end else if (type_arp) begin
            buf_start = 1'b1;
            state_d   = PAYLOAD;
          end else begin
            state_d = DISCARD;
          end
        end
      end
`endif
      PAYLOAD: begin
        if (beat) begin
          buf_wr = 1'b1;
          if (wr_idx == ARP_LAST_IDX) begin
            if (i_rx_last) begin
              accept_d = 1'b1;
              state_d  = SEND;
            end else begin
              state_d = DRAIN;
            end
          end else if (i_rx_last) begin
            o_frm_drop = 1'b1;
            state_d    = HDR;
          end
        end
      end
      DRAIN: begin
        if (beat && i_rx_last) begin
          accept_d = 1'b1;
          state_d  = SEND;
        end
      end
      DISCARD: begin
        if (beat && i_rx_last) begin
          o_frm_drop = 1'b1;
          state_d    = HDR;
        end
      end
      SEND: begin
        if (i_arp_ready) begin
          buf_rd_adv = 1'b1;
          if (rd_idx == ARP_LAST_IDX) begin
            state_d = HDR;
          end
        end
      end
      default: begin
        state_d = HDR;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= HDR;
      widx_q     <= 4'd0;
      hi_local_q <= 1'b0;
      hi_bcast_q <= 1'b0;
      mac_ok_q   <= 1'b0;
      en_q       <= 1'b0;
      accept_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      widx_q     <= widx_d;
      hi_local_q <= hi_local_d;
      hi_bcast_q <= hi_bcast_d;
      mac_ok_q   <= mac_ok_d;
      en_q       <= en_d;
      accept_q   <= accept_d;
    end
  end
endmodule
